spine_router: RTL
=================

# spine_router

Spine-side switch that terminates the four leaf-router spine links of one group and forwards packets between them, with one uplink toward the super-spine for out-of-group traffic. Each leaf router's `spineN4_*` port pair connects to one leaf port here. The block owns the input buffering and per-output arbitration that the leaf router ties off. It adds backpressure on every input and a registered, ready/valid output on every port.

## Interface
- `DWIDTH`, 16, payload width.
- `FIFO_DEPTH`, 8, entries per input FIFO; power of two, ≥2.
- `GROUP_ID`, 4'b0101, group served by this spine.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `leaf_in_data`  in  4*DWIDTH  packed, leaf k at `[k*DWIDTH +: DWIDTH]`.
- `leaf_in_valid`  in  4  per-leaf input valid.
- `leaf_in_dest`  in  4*6  per-leaf 6-bit destination address.
- `leaf_in_ready`  out  4  per-leaf input ready (= FIFO not full).
- `leaf_out_data`  out  4*DWIDTH  toward leaf k.
- `leaf_out_valid`  out  4  output valid.
- `leaf_out_dest`  out  4*6  destination forwarded with the packet.
- `leaf_out_ready`  in  4  leaf accepts output (tie to 1 for current leaf routers).
- `up_in_data`, `up_in_valid`, `up_in_dest`, `up_in_ready`: DWIDTH, 1, 6, 1; uplink input, same rules; input index 4.
- `up_out_data`, `up_out_valid`, `up_out_dest`, `up_out_ready`: DWIDTH, 1, 6, 1; uplink output, output index 4.
- `fifo_full`  out  5  per-input FIFO full, bit 4 = uplink.
- `fifo_empty`  out  5  per-input FIFO empty.
- `drop_count`  out  8  saturating count of dropped packets.
- `busy`  out  1  OR of all output valids.

## Operation
- Address: `dest[5:2]` = group, `dest[1:0]` = leaf index within group.
- Input i pushes `{dest,data}` when `valid & ready`. `ready = !full`, evaluated before any same-cycle pop. No push on full, even if popping.
- Route of a FIFO head:
  - `dest[5:2]==GROUP_ID` → leaf output `dest[1:0]`. Same-leaf U-turn is allowed.
  - Else, from a leaf input → uplink output 4.
  - Else, from the uplink input → dropped.
- Drop: pop the head with no output activity. `drop_count` increments and saturates at 255. Drops need no grant and are unaffected by output state.
- Each output o has an output register (valid, data, dest). It is free when `!out_valid | out_ready`.
- Arbitration: among non-empty inputs whose head routes to o, round-robin with a per-output pointer `ptr_o` (0..4).
  - Search order is ptr_o, ptr_o+1 … mod 5.
  - On grant to i: load the register, pop FIFO i, set `ptr_o = (i+1) mod 5`.
  - No grant → pointer holds.
- If o is not free, hold the register and pop nothing.
- If free with no grant, clear `out_valid`.
- One input heads exactly one route, so at most one pop per FIFO per cycle.
- Ordering is preserved per input→output pair.

## Timing
- Reset (async assert): all FIFOs empty, all `*_out_valid`=0, out data/dest=0, all `ptr_o`=0, `drop_count`=0.
  - During reset: `fifo_empty`=5'h1F, `fifo_full`=0, `*_in_ready`=1, `busy`=0.
  - A mid-packet reset discards all buffered packets.
- Latency: input sampled at edge E0 → head visible after E0 → output register loaded at E1. `out_valid` is high in the cycle after the input cycle, so minimum latency is 1 cycle.
- Throughput: one packet per output per cycle while the output is free.
- Back-to-back bursts from one input to one output stream with no bubbles.
- A stalled output (`out_ready`=0) holds data, dest and valid stable until accepted.
- `fifo_full` asserts at FIFO_DEPTH occupancy. Occupancy counter is log2(FIFO_DEPTH)+1 bits; pointers wrap mod FIFO_DEPTH.
- Contention: with 5 inputs persistently targeting one output, grants rotate 0,1,2,3,4,0…, each input once per 5 cycles.

## Test plan
- **Single hop:** after reset, leaf0 sends data 16'hA5A5, dest 6'b0101_10 → `leaf_out_valid[2]`=1 with data A5A5 one cycle later. All other outputs stay 0. `drop_count`=0.
- **Uplink / drop:**
  - leaf1 sends dest 6'b0011_01 → appears on `up_out` with dest 6'b0011_01.
  - Uplink sends dest 6'b0011_01 → dropped; `drop_count`=1; no output valid.
- **Round robin:** leaves 0–3 and uplink each hold 3 packets to leaf 3 → output order by source is 0,1,2,3,4,0,1,2,3,4,0,1,2,3,4 over 15 consecutive cycles.
- **Backpressure / full:** hold `leaf_out_ready[1]`=0 while leaf0 streams 10 packets to leaf 1.
  - Output register holds packet 1.
  - FIFO accepts 8 more, then `leaf_in_ready[0]`=0 and `fifo_full[0]`=1.
  - Release ready → all 9 delivered in order, no loss.
- **Reset mid-operation:** assert reset with 4 packets queued and an output valid → all outputs 0 immediately, `fifo_empty`=5'h1F. After release no stale packet emerges.
- **Drop saturation:** 260 uplink packets with a foreign group → `drop_count`=255, holds.

Source files
------------

// File: rtl/spine_router_if.sv
// Bundle of the spine router's leaf and uplink ready/valid ports plus status.
// The slave modport is the router side; the master modport is the driver side.
interface spine_router_if #(
    parameter int DWIDTH = 16
);
    logic [4*DWIDTH-1:0] leaf_in_data;
    logic [3:0]          leaf_in_valid;
    logic [23:0]         leaf_in_dest;
    logic [3:0]          leaf_in_ready;

    logic [4*DWIDTH-1:0] leaf_out_data;
    logic [3:0]          leaf_out_valid;
    logic [23:0]         leaf_out_dest;
    logic [3:0]          leaf_out_ready;

    logic [DWIDTH-1:0]   up_in_data;
    logic                up_in_valid;
    logic [5:0]          up_in_dest;
    logic                up_in_ready;

    logic [DWIDTH-1:0]   up_out_data;
    logic                up_out_valid;
    logic [5:0]          up_out_dest;
    logic                up_out_ready;

    logic [4:0]          fifo_full;
    logic [4:0]          fifo_empty;
    logic [7:0]          drop_count;
    logic                busy;

    modport slave (
        input  leaf_in_data, leaf_in_valid, leaf_in_dest, leaf_out_ready,
        input  up_in_data, up_in_valid, up_in_dest, up_out_ready,
        output leaf_in_ready, leaf_out_data, leaf_out_valid, leaf_out_dest,
        output up_in_ready, up_out_data, up_out_valid, up_out_dest,
        output fifo_full, fifo_empty, drop_count, busy
    );

    modport master (
        output leaf_in_data, leaf_in_valid, leaf_in_dest, leaf_out_ready,
        output up_in_data, up_in_valid, up_in_dest, up_out_ready,
        input  leaf_in_ready, leaf_out_data, leaf_out_valid, leaf_out_dest,
        input  up_in_ready, up_out_data, up_out_valid, up_out_dest,
        input  fifo_full, fifo_empty, drop_count, busy
    );
endinterface

// File: rtl/spine_router.sv
// Spine switch: five input FIFOs (leaf 0..3, uplink 4), per-output round-robin
// arbitration, registered ready/valid outputs and a saturating drop counter.
// Packets for this group go to leaf dest[1:0]; foreign packets from leaves go
// up; foreign packets arriving on the uplink are dropped.
module spine_router #(
    parameter int         DWIDTH     = 16,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [3:0] GROUP_ID   = 4'b0101
) (
    input  logic          clk,
    input  logic          reset,
    spine_router_if.slave bus
);
    localparam int NP = 5;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DWIDTH + 6;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    // Unpacked per-port views of the bus (index 4 = uplink)
    logic [DWIDTH-1:0] in_data [NP];
    logic [5:0]        in_dest [NP];
    logic [NP-1:0]     in_valid;
    logic [NP-1:0]     out_ready;

    // Input FIFO state
    logic [AW-1:0]     wr_ptr_q [NP];
    logic [AW-1:0]     rd_ptr_q [NP];
    logic [AW:0]       count_q  [NP];
    logic [NP-1:0]     fifo_full_w;
    logic [NP-1:0]     fifo_empty_w;
    logic [NP-1:0]     push;
    logic [NP-1:0]     pop;

    // Head-of-line routing
    logic [EW-1:0]     head_entry [NP];
    logic [5:0]        head_dest  [NP];
    logic [DWIDTH-1:0] head_data  [NP];
    logic [2:0]        route_sel  [NP];
    logic [NP-1:0]     route_ok;
    logic [NP-1:0]     drop_req;

    // Arbitration, indexed [output][input]
    logic [NP-1:0]     req     [NP];
    logic [NP-1:0]     gnt     [NP];
    logic              gnt_any [NP];
    logic [2:0]        gnt_idx [NP];
    logic [2:0]        rr_ptr_q [NP];

    // Output registers
    logic [NP-1:0]     out_valid_q;
    logic [NP-1:0]     out_free;
    logic [DWIDTH-1:0] out_data_q [NP];
    logic [5:0]        out_dest_q [NP];
    logic [7:0]        drop_count_q;

    logic [4*DWIDTH-1:0] leaf_out_data_w;
    logic [23:0]         leaf_out_dest_w;

    assign in_valid  = {bus.up_in_valid, bus.leaf_in_valid};
    assign out_ready = {bus.up_out_ready, bus.leaf_out_ready};

    // Split the packed leaf buses into per-port data/dest
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            in_data[k] = bus.leaf_in_data[k*DWIDTH +: DWIDTH];
            in_dest[k] = bus.leaf_in_dest[k*6 +: 6];
        end
        in_data[4] = bus.up_in_data;
        in_dest[4] = bus.up_in_dest;
    end

    genvar gi, go;
    generate
        for (gi = 0; gi < NP; gi++) begin : g_in
            logic [EW-1:0] mem_q [FIFO_DEPTH];
            logic          is_local;

            assign fifo_full_w[gi]  = (count_q[gi] == FULL_CNT);
            assign fifo_empty_w[gi] = (count_q[gi] == '0);
            // Ready depends only on the registered count, so a pop in the
            // same cycle never opens room for a push into a full FIFO.
            assign push[gi] = in_valid[gi] & ~fifo_full_w[gi];

            // FIFO storage write; head is read asynchronously for 1-cycle latency
            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    mem_q[wr_ptr_q[gi]] <= {in_dest[gi], in_data[gi]};
                end
            end

            assign head_entry[gi] = mem_q[rd_ptr_q[gi]];
            assign head_dest[gi]  = head_entry[gi][EW-1 -: 6];
            assign head_data[gi]  = head_entry[gi][DWIDTH-1:0];
            assign is_local       = (head_dest[gi][5:2] == GROUP_ID);
            assign route_sel[gi]  = is_local ? {1'b0, head_dest[gi][1:0]} : 3'd4;

            if (gi == NP-1) begin : g_up
                // Foreign traffic from the super-spine has nowhere to go
                assign route_ok[gi] = ~fifo_empty_w[gi] & is_local;
                assign drop_req[gi] = ~fifo_empty_w[gi] & ~is_local;
            end else begin : g_leaf
                assign route_ok[gi] = ~fifo_empty_w[gi];
                assign drop_req[gi] = 1'b0;
            end

            for (go = 0; go < NP; go++) begin : g_req
                assign req[go][gi] = route_ok[gi] && (route_sel[gi] == 3'(go));
            end
        end

        for (go = 0; go < NP; go++) begin : g_arb
            assign out_free[go] = ~out_valid_q[go] | out_ready[go];

            // Round-robin search starting at this output's pointer
            always_comb begin
                logic [3:0] idx;
                idx          = '0;
                gnt_any[go]  = 1'b0;
                gnt_idx[go]  = '0;
                gnt[go]      = '0;
                for (int k = 0; k < NP; k++) begin
                    idx = {1'b0, rr_ptr_q[go]} + 4'(k);
                    if (idx >= 4'd5) begin
                        idx = idx - 4'd5;
                    end
                    if (!gnt_any[go] && req[go][idx[2:0]]) begin
                        gnt_any[go] = 1'b1;
                        gnt_idx[go] = idx[2:0];
                    end
                end
                if (gnt_any[go] && out_free[go]) begin
                    gnt[go][gnt_idx[go]] = 1'b1;
                end
            end
        end
    endgenerate

    // Each head has a single route, so OR-ing grants gives at most one pop per FIFO
    always_comb begin
        pop = drop_req;
        for (int o = 0; o < NP; o++) begin
            pop = pop | gnt[o];
        end
    end

    // FIFO pointer and occupancy update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NP; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NP; i++) begin
                if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
                if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
                case ({push[i], pop[i]})
                    2'b10:   count_q[i] <= count_q[i] + 1'b1;
                    2'b01:   count_q[i] <= count_q[i] - 1'b1;
                    default: count_q[i] <= count_q[i];
                endcase
            end
        end
    end

    // Output registers and round-robin pointers; a stalled output holds everything
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= '0;
            for (int o = 0; o < NP; o++) begin
                out_data_q[o] <= '0;
                out_dest_q[o] <= '0;
                rr_ptr_q[o]   <= '0;
            end
        end else begin
            for (int o = 0; o < NP; o++) begin
                if (out_free[o]) begin
                    if (gnt_any[o]) begin
                        out_valid_q[o] <= 1'b1;
                        out_data_q[o]  <= head_data[gnt_idx[o]];
                        out_dest_q[o]  <= head_dest[gnt_idx[o]];
                        rr_ptr_q[o]    <= (gnt_idx[o] == 3'd4) ? 3'd0 : gnt_idx[o] + 3'd1;
                    end else begin
                        out_valid_q[o] <= 1'b0;
                    end
                end
            end
        end
    end

    // Saturating count of uplink packets discarded for a foreign group
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count_q <= '0;
        end else if ((|drop_req) && (drop_count_q != 8'hFF)) begin
            drop_count_q <= drop_count_q + 8'd1;
        end
    end

    // Repack per-port output registers onto the leaf buses
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            leaf_out_data_w[k*DWIDTH +: DWIDTH] = out_data_q[k];
            leaf_out_dest_w[k*6 +: 6]           = out_dest_q[k];
        end
    end

    assign bus.leaf_in_ready  = ~fifo_full_w[3:0];
    assign bus.up_in_ready    = ~fifo_full_w[4];
    assign bus.leaf_out_data  = leaf_out_data_w;
    assign bus.leaf_out_dest  = leaf_out_dest_w;
    assign bus.leaf_out_valid = out_valid_q[3:0];
    assign bus.up_out_data    = out_data_q[4];
    assign bus.up_out_dest    = out_dest_q[4];
    assign bus.up_out_valid   = out_valid_q[4];
    assign bus.fifo_full      = fifo_full_w;
    assign bus.fifo_empty     = fifo_empty_w;
    assign bus.drop_count     = drop_count_q;
    assign bus.busy           = |out_valid_q;
endmodule
